// File: rtl/mcpd_pkg.sv
// Shared types for the multi-channel pulse detector:
// edge-select encoding and the per-channel width FSM states.
package mcpd_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LONG = 2'd2
  } pd_state_t;

endpackage

// File: rtl/pulse_width_channel.sv
// One input channel: width FSM, selectable edge detect,
// in-range pulse-end detect and a sticky seen flag.
module pulse_width_channel
  import mcpd_pkg::*;
#(
  parameter int MIN_W = 1,
  parameter int MAX_W = 1,
  localparam int CNT_W = $clog2(MAX_W + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic [1:0] edge_mode,
  input  logic       clr,
  output logic       edge_det,
  output logic       pulse_det,
  output logic       sticky
);

  pd_state_t        r_st;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sticky;
  logic             w_rise;
  logic             w_fall;
  logic             w_edge;
  logic             w_pulse;

  assign w_rise = a & (r_st == IDLE);
  assign w_fall = ~a & (r_st != IDLE);

  always_comb begin
    w_edge = 1'b0;
    case (edge_mode_t'(edge_mode))
      EDGE_RISE: w_edge = w_rise;
      EDGE_FALL: w_edge = w_fall;
      EDGE_BOTH: w_edge = w_rise | w_fall;
      default:   w_edge = 1'b0;
    endcase
  end

  assign w_pulse = ~a & (r_st == HIGH)
                 & (r_cnt >= CNT_W'(MIN_W));

  // Mealy outputs are masked so nothing leaks out while held in reset.
  assign edge_det  = w_edge & rst_n;
  assign pulse_det = w_pulse & rst_n;
  assign sticky    = r_sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st  <= IDLE;
      r_cnt <= '0;
    end else begin
      case (r_st)
        IDLE: if (a) begin
          r_st  <= HIGH;
          r_cnt <= CNT_W'(1);
        end
        HIGH: if (!a) begin
          r_st  <= IDLE;
          r_cnt <= '0;
        end else if (r_cnt == CNT_W'(MAX_W)) begin
          r_st  <= LONG;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        LONG: if (!a) begin
          r_st  <= IDLE;
          r_cnt <= '0;
        end
        default: begin
          r_st  <= IDLE;
          r_cnt <= '0;
        end
      endcase
    end
  end

  // A detection in the same cycle as clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_sticky <= 1'b0;
    else if (w_pulse) r_sticky <= 1'b1;
    else if (clr)     r_sticky <= 1'b0;
  end

endmodule

// File: rtl/multi_channel_pulse_detector.sv
// N_CH independent edge / pulse-width detectors with
// a shared edge mode and a shared sticky clear.
module multi_channel_pulse_detector
  import mcpd_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int MIN_W = 1,
  parameter int MAX_W = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] a,
  input  logic [1:0]      edge_mode,
  input  logic            clr,
  output logic [N_CH-1:0] edge_det,
  output logic [N_CH-1:0] pulse_det,
  output logic [N_CH-1:0] sticky
);

  if (MIN_W < 1 || MAX_W < MIN_W || N_CH < 1) begin : g_bad_cfg
    $fatal(1, "multi_channel_pulse_detector: bad N_CH/MIN_W/MAX_W");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pulse_width_channel #(
      .MIN_W(MIN_W),
      .MAX_W(MAX_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a[i]),
      .edge_mode(edge_mode),
      .clr      (clr),
      .edge_det (edge_det[i]),
      .pulse_det(pulse_det[i]),
      .sticky   (sticky[i])
    );
  end

endmodule
